// File: rtl/mvu_job_ctrl_if.sv
// Job / completion / MVU handshake bundle for mvu_job_ctrl.
// slave is the controller side, master is the host/MVU side.
interface mvu_job_ctrl_if #(
   parameter int ID_W  = 4,
   parameter int LEN_W = 16
);
   logic             job_valid;
   logic             job_ready;
   logic [ID_W-1:0]  job_id;
   logic [LEN_W-1:0] job_len;
   logic             mvu_start;
   logic             mvu_out_valid;
   logic             done_valid;
   logic             done_ready;
   logic [ID_W-1:0]  done_id;
   logic [1:0]       done_status;
   logic [LEN_W-1:0] done_count;

   modport slave (
      input  job_valid, job_id, job_len, mvu_out_valid, done_ready,
      output job_ready, mvu_start, done_valid, done_id, done_status, done_count
   );

   modport master (
      output job_valid, job_id, job_len, mvu_out_valid, done_ready,
      input  job_ready, mvu_start, done_valid, done_id, done_status, done_count
   );
endinterface

// File: rtl/mvu_job_ctrl.sv
// MVU job controller: accepts a job descriptor, starts the MVU, counts output
// words with an idle watchdog, and holds a completion record until consumed.
module mvu_job_ctrl #(
   parameter int ID_W  = 4,
   parameter int LEN_W = 16,
   parameter int TO_W  = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   mvu_job_ctrl_if.slave   bus,
   input  logic [TO_W-1:0] timeout_cyc,
   input  logic            irq_clr,
   output logic            busy,
   output logic            irq,
   output logic            spurious
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_START  = 2'd1;
   localparam logic [1:0] S_RUN    = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ZLEN    = 2'b10;

   logic [1:0]       state;
   logic [ID_W-1:0]  id_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [TO_W-1:0]  wd;
   logic [TO_W-1:0]  to_q;
   logic             start_q;
   logic [ID_W-1:0]  done_id_q;
   logic [1:0]       done_status_q;
   logic [LEN_W-1:0] done_count_q;
   logic [LEN_W-1:0] cnt_inc;
   logic [TO_W-1:0]  wd_inc;

   assign cnt_inc = cnt + LEN_W'(1);
   assign wd_inc  = wd + TO_W'(1);

   assign bus.job_ready   = (state == S_IDLE);
   assign bus.done_valid  = (state == S_REPORT);
   assign busy            = (state != S_IDLE);
   assign bus.mvu_start   = start_q;
   assign bus.done_id     = done_id_q;
   assign bus.done_status = done_status_q;
   assign bus.done_count  = done_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         id_q          <= '0;
         len_q         <= '0;
         cnt           <= '0;
         wd            <= '0;
         to_q          <= '0;
         start_q       <= 1'b0;
         done_id_q     <= '0;
         done_status_q <= ST_OK;
         done_count_q  <= '0;
         irq           <= 1'b0;
         spurious      <= 1'b0;
      end else begin
         start_q <= 1'b0;

         // Clear first; a REPORT entry below overrides it so set wins.
         if (irq_clr)
            irq <= 1'b0;

         if (bus.mvu_out_valid && state != S_RUN)
            spurious <= 1'b1;
         else if (irq_clr)
            spurious <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.job_valid) begin
                  id_q  <= bus.job_id;
                  len_q <= bus.job_len;
                  if (bus.job_len == '0) begin
                     state         <= S_REPORT;
                     done_id_q     <= bus.job_id;
                     done_status_q <= ST_ZLEN;
                     done_count_q  <= '0;
                     irq           <= 1'b1;
                  end else begin
                     state   <= S_START;
                     start_q <= 1'b1;
                  end
               end
            end
            S_START: begin
               cnt   <= '0;
               wd    <= '0;
               to_q  <= timeout_cyc;
               state <= S_RUN;
            end
            S_RUN: begin
               // A word in the expiry cycle resets the watchdog, so OK wins.
               if (bus.mvu_out_valid) begin
                  cnt <= cnt_inc;
                  wd  <= '0;
                  if (cnt_inc == len_q) begin
                     state         <= S_REPORT;
                     done_id_q     <= id_q;
                     done_status_q <= ST_OK;
                     done_count_q  <= cnt_inc;
                     irq           <= 1'b1;
                  end
               end else begin
                  wd <= wd_inc;
                  if (to_q != '0 && wd_inc == to_q) begin
                     state         <= S_REPORT;
                     done_id_q     <= id_q;
                     done_status_q <= ST_TIMEOUT;
                     done_count_q  <= cnt;
                     irq           <= 1'b1;
                  end
               end
            end
            S_REPORT: begin
               if (bus.done_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Scoreboard bench for mvu_job_ctrl: expected completion records are queued at
// job submission and compared when the controller presents them.
module tb_mvu_job_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] timeout_cyc;
   logic        irq_clr;
   logic        busy;
   logic        irq;
   logic        spurious;

   typedef struct packed {
      logic [3:0]  id;
      logic [1:0]  st;
      logic [15:0] cnt;
   } rec_t;

   rec_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   starts = 0;

   mvu_job_ctrl_if #(.ID_W(4), .LEN_W(16)) bus ();

   mvu_job_ctrl #(.ID_W(4), .LEN_W(16), .TO_W(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .timeout_cyc (timeout_cyc),
      .irq_clr     (irq_clr),
      .busy        (busy),
      .irq         (irq),
      .spurious    (spurious)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.mvu_start === 1'b1)
         starts++;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string name);
      logic [27:0] obs;
      obs = {bus.job_ready, bus.done_valid, busy, irq, spurious, bus.mvu_start,
             bus.done_id, bus.done_status, bus.done_count};
      total++;
      if (obs !== {6'b100000, 22'd0}) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, obs, {6'b100000, 22'd0});
      end
   endtask

   task automatic submit(input logic [3:0] id, input logic [15:0] len);
      total++;
      if (bus.job_ready !== 1'b1) begin
         bad++;
         $display("FAIL submit_ready: job_ready=%b required 1", bus.job_ready);
      end
      bus.job_valid = 1'b1;
      bus.job_id    = id;
      bus.job_len   = len;
      tick();
      bus.job_valid = 1'b0;
      total++;
      if (bus.mvu_start !== (len != 16'd0)) begin
         bad++;
         $display("FAIL submit_start: mvu_start=%b required %b", bus.mvu_start, len != 16'd0);
      end
   endtask

   task automatic words(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bus.mvu_out_valid = 1'b1;
         tick();
         bus.mvu_out_valid = 1'b0;
         if (i < n - 1)
            repeat (gap) tick();
      end
   endtask

   task automatic wait_done(input int maxc, output int waited);
      rec_t e;
      rec_t obs;
      waited = 0;
      while (bus.done_valid !== 1'b1 && waited < maxc) begin
         tick();
         waited++;
      end
      total++;
      if (bus.done_valid !== 1'b1) begin
         bad++;
         $display("FAIL done_wait: done_valid=%b after %0d cycles required 1", bus.done_valid, waited);
      end else if (sbq.size() == 0) begin
         bad++;
         $display("FAIL done_unexpected: record %h with empty scoreboard", {bus.done_id, bus.done_status, bus.done_count});
      end else begin
         e   = sbq.pop_front();
         obs = {bus.done_id, bus.done_status, bus.done_count};
         if (obs !== e) begin
            bad++;
            $display("FAIL done_record: id=%0d st=%b cnt=%0d required id=%0d st=%b cnt=%0d",
                     obs.id, obs.st, obs.cnt, e.id, e.st, e.cnt);
         end
         total++;
         if (irq !== 1'b1) begin
            bad++;
            $display("FAIL done_irq: irq=%b required 1", irq);
         end
         bus.done_ready = 1'b1;
         tick();
         bus.done_ready = 1'b0;
         total++;
         if (bus.job_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_release: job_ready=%b busy=%b required 1 0", bus.job_ready, busy);
         end
      end
   endtask

   task automatic clear_irq();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n             = 1'b0;
      timeout_cyc       = '0;
      irq_clr           = 1'b0;
      bus.job_valid     = 1'b0;
      bus.job_id        = '0;
      bus.job_len       = '0;
      bus.mvu_out_valid = 1'b0;
      bus.done_ready    = 1'b0;
      repeat (3) tick();
      check_reset_vals("reset_state");
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      int s0;
      int w;
      s0 = starts;
      timeout_cyc = 20'd100;
      sbq.push_back('{id: 4'd3, st: 2'b00, cnt: 16'd4});
      submit(4'd3, 16'd4);
      tick();
      total++;
      if (bus.mvu_start !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL normal_run: mvu_start=%b busy=%b required 0 1", bus.mvu_start, busy);
      end
      words(4, 2);
      wait_done(20, w);
      total++;
      if (starts - s0 !== 1) begin
         bad++;
         $display("FAIL normal_starts: pulses=%0d required 1", starts - s0);
      end
      clear_irq();
   endtask

   task automatic test_zero_len();
      int s0;
      int w;
      s0 = starts;
      sbq.push_back('{id: 4'd5, st: 2'b10, cnt: 16'd0});
      submit(4'd5, 16'd0);
      wait_done(5, w);
      total++;
      if (w !== 0 || starts != s0) begin
         bad++;
         $display("FAIL zero_len_timing: wait=%0d pulses=%0d required 0 0", w, starts - s0);
      end
      clear_irq();
   endtask

   task automatic test_timeout();
      int w;
      timeout_cyc = 20'd10;
      sbq.push_back('{id: 4'd7, st: 2'b01, cnt: 16'd3});
      submit(4'd7, 16'd8);
      tick();
      timeout_cyc = 20'd2;
      words(3, 1);
      wait_done(30, w);
      total++;
      if (w !== 10) begin
         bad++;
         $display("FAIL timeout_latency: idle cycles=%0d required 10", w);
      end
      clear_irq();
   endtask

   task automatic test_race_backpressure();
      int w;
      logic [21:0] exp_rec;
      timeout_cyc = 20'd4;
      sbq.push_back('{id: 4'd9, st: 2'b00, cnt: 16'd2});
      exp_rec = {4'd9, 2'b00, 16'd2};
      submit(4'd9, 16'd2);
      tick();
      words(2, 3);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.done_valid !== 1'b1 || bus.job_ready !== 1'b0 ||
             {bus.done_id, bus.done_status, bus.done_count} !== exp_rec) begin
            bad++;
            $display("FAIL hold_%0d: valid=%b ready=%b rec=%h required 1 0 %h", i,
                     bus.done_valid, bus.job_ready,
                     {bus.done_id, bus.done_status, bus.done_count}, exp_rec);
         end
         tick();
      end
      wait_done(5, w);
      clear_irq();
   endtask

   task automatic test_sticky();
      int w;
      sbq.push_back('{id: 4'd2, st: 2'b10, cnt: 16'd0});
      irq_clr = 1'b1;
      submit(4'd2, 16'd0);
      irq_clr = 1'b0;
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_set_wins: irq=%b required 1", irq);
      end
      wait_done(5, w);
      bus.mvu_out_valid = 1'b1;
      tick();
      bus.mvu_out_valid = 1'b0;
      total++;
      if (spurious !== 1'b1) begin
         bad++;
         $display("FAIL spurious_set: spurious=%b required 1", spurious);
      end
      bus.mvu_out_valid = 1'b1;
      irq_clr = 1'b1;
      tick();
      bus.mvu_out_valid = 1'b0;
      irq_clr = 1'b0;
      total++;
      if (spurious !== 1'b1) begin
         bad++;
         $display("FAIL spurious_set_wins: spurious=%b required 1", spurious);
      end
      clear_irq();
      total++;
      if ({irq, spurious} !== 2'b00) begin
         bad++;
         $display("FAIL sticky_clear: irq=%b spurious=%b required 0 0", irq, spurious);
      end
   endtask

   task automatic test_reset_midrun();
      int w;
      int dv = 0;
      timeout_cyc = '0;
      submit(4'd4, 16'd6);
      tick();
      words(2, 1);
      repeat (25) tick();
      total++;
      if (busy !== 1'b1 || bus.done_valid !== 1'b0) begin
         bad++;
         $display("FAIL watchdog_disabled: busy=%b done_valid=%b required 1 0", busy, bus.done_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("reset_async");
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done_valid !== 1'b0) dv++;
      end
      check_reset_vals("reset_held");
      rst_n = 1'b1;
      total++;
      if (dv != 0) begin
         bad++;
         $display("FAIL reset_no_done: done_valid cycles=%0d required 0", dv);
      end
      timeout_cyc = 20'd50;
      sbq.push_back('{id: 4'd6, st: 2'b00, cnt: 16'd3});
      submit(4'd6, 16'd3);
      tick();
      words(3, 0);
      wait_done(10, w);
      clear_irq();
   endtask

   task automatic test_back_to_back();
      int w;
      sbq.push_back('{id: 4'd11, st: 2'b10, cnt: 16'd0});
      sbq.push_back('{id: 4'd12, st: 2'b00, cnt: 16'd1});
      submit(4'd11, 16'd0);
      wait_done(5, w);
      submit(4'd12, 16'd1);
      tick();
      words(1, 0);
      wait_done(5, w);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_empty: %0d records left required 0", sbq.size());
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_zero_len();
      test_timeout();
      test_race_backpressure();
      test_sticky();
      test_reset_midrun();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mvu_job_ctrl.md
MVU_JOB_CTRL -- requirements
Module: mvu_job_ctrl

Interface
REQ-001 Parameter ID_W, default 4, job identifier width.
REQ-002 Parameter LEN_W, default 16, expected output-word count width.
REQ-003 Parameter TO_W, default 20, watchdog counter width.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 job_valid  in  1  host presents a job descriptor.
REQ-008 job_ready  out  1  block accepts a descriptor this cycle.
REQ-009 job_id  in  ID_W  job tag, echoed on completion.
REQ-010 job_len  in  LEN_W  number of MVU output words expected.
REQ-011 timeout_cyc  in  TO_W  idle-cycle watchdog limit; 0 disables.
REQ-012 mvu_start  out  1  one-cycle start pulse to the MVU.
REQ-013 mvu_out_valid  in  1  one MVU output word produced this cycle.
REQ-014 done_valid  out  1  completion record valid.
REQ-015 done_ready  in  1  host consumes the completion record.
REQ-016 done_id  out  ID_W  tag of the completed job.
REQ-017 done_status  out  2  00 OK, 01 TIMEOUT, 10 ZERO_LEN, 11 reserved (never driven).
REQ-018 done_count  out  LEN_W  output words counted for the job.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 irq  out  1  sticky completion interrupt.
REQ-021 spurious  out  1  sticky flag: mvu_out_valid seen outside RUN.
REQ-022 irq_clr  in  1  clears irq and spurious.

Function
REQ-023 FSM states IDLE, START, RUN, REPORT; job_ready = (state==IDLE).
REQ-024 IDLE: on job_valid, latch job_id and job_len; len!=0 -> START; len==0 -> REPORT with status ZERO_LEN, count 0, no mvu_start.
REQ-025 START: mvu_start=1 for exactly this cycle; word counter and watchdog cleared; -> RUN. A job accepted at edge T therefore pulses mvu_start in cycle T+1.
REQ-026 RUN: each cycle with mvu_out_valid increments the word counter (LEN_W bits, no wrap possible because exit occurs at len).
REQ-027 RUN: a mvu_out_valid that brings the count to job_len -> REPORT, status OK, at the next edge.
REQ-028 RUN: the watchdog increments on each cycle without mvu_out_valid and clears on each cycle with it; watchdog reaching timeout_cyc (timeout_cyc!=0) -> REPORT, status TIMEOUT, done_count = words so far.
REQ-029 A final word and a watchdog expiry in the same cycle: OK wins.
REQ-030 timeout_cyc is sampled in START; changes during RUN have no effect on the current job.
REQ-031 REPORT: done_valid=1; done_id, done_status and done_count are held stable until done_ready; done_valid & done_ready -> IDLE. job_ready stays low in REPORT.
REQ-032 irq is set on the edge entering REPORT; irq_clr clears irq; a simultaneous set and clear leaves irq=1.
REQ-033 mvu_out_valid in IDLE, START or REPORT is not counted and sets spurious; irq_clr clears spurious, with set winning over clear.
REQ-034 All outputs are registered except job_ready, done_valid and busy, which decode the state register directly.

Reset
REQ-035 rst_n low, at any time including mid-job, forces IDLE, mvu_start=0, done_valid=0, done_id=0, done_status=00, done_count=0, busy=0, irq=0, spurious=0, counters=0, and job_ready=1; an in-flight job is discarded without a completion record.
REQ-036 After rst_n deasserts, the first job can be accepted on the first rising edge.

Verification
REQ-037 Normal: job id=3, len=4, timeout=100; 4 valids spaced 2 cycles apart -> one mvu_start pulse at T+1; done id=3, status 00, count 4; irq=1.
REQ-038 Zero length: job id=5, len=0 -> no mvu_start; next cycle done_valid with status 10, count 0.
REQ-039 Timeout: len=8, timeout=10, 3 valids then silence -> status 01, count 3, done_valid exactly 10 idle cycles after the 3rd valid.
REQ-040 Race and backpressure: the last valid coincides with watchdog expiry -> status 00; hold done_ready=0 for 5 cycles -> done fields stable and job_ready=0 throughout.
REQ-041 Sticky flags: valid in IDLE -> spurious=1; irq_clr together with a REPORT entry -> irq=1; irq_clr alone -> irq=0 and spurious=0.
REQ-042 Reset mid-RUN after 2 of 6 words -> all outputs at reset values, no done_valid; a new job then runs normally.
